// File: rtl/u_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : u_game_pkg
//  Purpose  : Shared definitions for the note scheduler and the LED lane:
//             state encoding, lane geometry, default lane speed and the
//             built-in chart pattern.
//  Revision : 1.0  initial release
// ============================================================================
package u_game_pkg;

    // Number of LED positions in the lane.
    localparam int LANE_LEN           = 8;
    // One strobe for the lane to consume the last bit, then one per position.
    localparam int DRAIN_STEPS        = LANE_LEN + 1;
    // 1 ms ticks per lane step; the lane block uses the same default.
    localparam int NOTE_SPEED_DEFAULT = 200;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_PLAY  = 3'd2,
        S_DRAIN = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    // Built-in chart: the four-step figure 1,0,1,1 repeated along the chart.
    function automatic logic chart_pattern(input int idx);
        return (idx % 4) != 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/u_chart_rom.sv
`default_nettype none
// ============================================================================
//  Module   : u_chart_rom
//  Purpose  : CHART_LEN x 1-bit chart storage, combinational read.
//  Ports    : i_addr  chart index to read
//             o_bit   note bit stored at i_addr
//  Revision : 1.0  initial release
// ============================================================================
module u_chart_rom
    import u_game_pkg::*;
#(
    parameter int CHART_LEN = 64,
    localparam int IW = $clog2(CHART_LEN)
) (
    input  logic [IW-1:0] i_addr,
    output logic          o_bit
);

    logic [CHART_LEN-1:0] w_table;

    generate
        for (genvar gi = 0; gi < CHART_LEN; gi++) begin : g_rom
            assign w_table[gi] = chart_pattern(gi);
        end
    endgenerate

    // CHART_LEN is a power of two, so every address value is in range.
    assign o_bit = w_table[i_addr];

endmodule
`default_nettype wire

// File: rtl/u_note_sched.sv
`default_nettype none
// ============================================================================
//  Module   : u_note_sched
//  Purpose  : Song scheduler for the LED note lane. Runs a count-in, then
//             issues one chart bit per lane step, then drains the lane and
//             reports completion. Supports pause/resume and abort.
//  Ports    : clk, rst       clock, synchronous active-high reset
//             i_tick         1 ms tick, one clk wide
//             i_start        begin a song (honoured in IDLE only)
//             i_pause        toggle pause (ignored in IDLE)
//             i_stop         abort the song
//             o_spawn_note   note bit for the lane's next shift (registered)
//             o_state        current state encoding
//             o_step_idx     next chart index to issue
//             o_lead_beat    one-clk pulse per count-in step
//             o_done         one-clk pulse on normal completion
//  Revision : 1.0  initial release
// ============================================================================
module u_note_sched
    import u_game_pkg::*;
#(
    parameter int NOTE_SPEED = NOTE_SPEED_DEFAULT,
    parameter int CHART_LEN  = 64,
    parameter int LEAD_STEPS = 8,
    localparam int IW = $clog2(CHART_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_start,
    input  logic          i_pause,
    input  logic          i_stop,
    output logic          o_spawn_note,
    output logic [2:0]    o_state,
    output logic [IW-1:0] o_step_idx,
    output logic          o_lead_beat,
    output logic          o_done
);

    localparam int TW = (NOTE_SPEED > 1) ? $clog2(NOTE_SPEED) : 1;
    localparam int LW = $clog2(LEAD_STEPS + 1);
    localparam int DW = $clog2(DRAIN_STEPS + 1);

    localparam logic [TW-1:0] c_TMR_LAST   = TW'(NOTE_SPEED - 1);
    localparam logic [LW-1:0] c_LEAD_LAST  = LW'(LEAD_STEPS - 1);
    localparam logic [DW-1:0] c_DRAIN_LAST = DW'(DRAIN_STEPS - 1);
    localparam logic [IW-1:0] c_IDX_LAST   = IW'(CHART_LEN - 1);

    logic [TW-1:0] r_timer;
    state_t        r_state;
    state_t        r_saved;
    logic [LW-1:0] r_lead_cnt;
    logic [DW-1:0] r_drain_cnt;
    logic [IW-1:0] r_idx;
    logic          r_spawn;
    logic          r_lead_beat;
    logic          r_done;

    state_t        w_state_nxt;
    state_t        w_saved_nxt;
    logic [LW-1:0] w_lead_nxt;
    logic [DW-1:0] w_drain_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic          w_spawn_nxt;
    logic          w_beat_nxt;
    logic          w_done_nxt;
    logic          w_strobe;
    logic          w_chart_bit;

    u_chart_rom #(
        .CHART_LEN (CHART_LEN)
    ) u_rom (
        .i_addr (r_idx),
        .o_bit  (w_chart_bit)
    );

    // Step strobe fires on the tick that leaves the timer at zero, which
    // puts it in phase with the lane's shift enable (same reset, same timer).
    assign w_strobe = i_tick && (r_timer == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_state     <= S_IDLE;
            r_saved     <= S_IDLE;
            r_lead_cnt  <= '0;
            r_drain_cnt <= '0;
            r_idx       <= '0;
            r_spawn     <= 1'b0;
            r_lead_beat <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (i_tick) begin
                r_timer <= (r_timer == c_TMR_LAST) ? '0 : r_timer + TW'(1);
            end
            r_state     <= w_state_nxt;
            r_saved     <= w_saved_nxt;
            r_lead_cnt  <= w_lead_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_idx       <= w_idx_nxt;
            r_spawn     <= w_spawn_nxt;
            r_lead_beat <= w_beat_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_lead_nxt  = r_lead_cnt;
        w_drain_nxt = r_drain_cnt;
        w_idx_nxt   = r_idx;
        w_spawn_nxt = r_spawn;
        w_beat_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        if (i_stop && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_spawn_nxt = 1'b0;
            w_idx_nxt   = '0;
            w_lead_nxt  = '0;
            w_drain_nxt = '0;
        end else if (i_pause && (r_state != S_IDLE)) begin
            // A strobe arriving in this cycle is deliberately dropped.
            if (r_state == S_PAUSE) begin
                w_state_nxt = r_saved;
            end else begin
                w_saved_nxt = r_state;
                w_state_nxt = S_PAUSE;
                w_spawn_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A coincident strobe is not a count-in step.
                    if (i_start) begin
                        w_state_nxt = S_LEAD;
                        w_lead_nxt  = '0;
                        w_idx_nxt   = '0;
                        w_spawn_nxt = 1'b0;
                    end
                end
                S_LEAD: begin
                    if (w_strobe) begin
                        w_beat_nxt = 1'b1;
                        w_lead_nxt = r_lead_cnt + LW'(1);
                        if (r_lead_cnt == c_LEAD_LAST) begin
                            w_state_nxt = S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_strobe) begin
                        w_spawn_nxt = w_chart_bit;
                        if (r_idx == c_IDX_LAST) begin
                            w_idx_nxt   = '0;
                            w_drain_nxt = '0;
                            w_state_nxt = S_DRAIN;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_strobe) begin
                        w_spawn_nxt = 1'b0;
                        w_drain_nxt = r_drain_cnt + DW'(1);
                        if (r_drain_cnt == c_DRAIN_LAST) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    // Frozen until i_pause or i_stop.
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign o_spawn_note = r_spawn;
    assign o_state      = r_state;
    assign o_step_idx   = r_idx;
    assign o_lead_beat  = r_lead_beat;
    assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_u_note_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_u_note_sched
//  Purpose  : Directed self-checking bench for u_note_sched with
//             NOTE_SPEED=4, CHART_LEN=4, LEAD_STEPS=2 (chart 1,0,1,1).
//             A small LED-lane shift model observes o_spawn_note at strobes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_u_note_sched;

    localparam int NS = 4;
    localparam int CL = 4;
    localparam int LS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_stop = 1'b0;
    logic       o_spawn_note;
    logic [2:0] o_state;
    logic [1:0] o_step_idx;
    logic       o_lead_beat;
    logic       o_done;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         tick_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] lane = 8'h00;
    logic [3:0] exp_led = 4'b1101;   // lane[7] sequence 1,0,1,1 (bit 0 first)
    logic       es;

    always #5 clk = ~clk;

    u_note_sched #(
        .NOTE_SPEED (NS),
        .CHART_LEN  (CL),
        .LEAD_STEPS (LS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_tick       (i_tick),
        .i_start      (i_start),
        .i_pause      (i_pause),
        .i_stop       (i_stop),
        .o_spawn_note (o_spawn_note),
        .o_state      (o_state),
        .o_step_idx   (o_step_idx),
        .o_lead_beat  (o_lead_beat),
        .o_done       (o_done)
    );

    always @(negedge clk) if (o_done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; a tick on a strobe phase shifts the lane.
    task automatic cyc(input logic t, input logic s, input logic p, input logic x);
        i_tick = t; i_start = s; i_pause = p; i_stop = x;
        if (t) begin
            if (tick_cnt % NS == 0) lane = {lane[6:0], o_spawn_note};
            tick_cnt++;
        end
        @(posedge clk); #1;
        i_tick = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    endtask

    task automatic tick1();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_state", o_state, 0);
        chk("rst_idx", o_step_idx, 0);
        chk("rst_spawn", o_spawn_note, 0);
        chk("rst_beat", o_lead_beat, 0);
        chk("rst_done", o_done, 0);
        rst = 1'b0; tick_cnt = 0; lane = 8'h00;

        // ---------------- normal run ----------------
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_state", o_state, 1);
        chk("start_idx", o_step_idx, 0);
        es = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick1();
            case (k)
                8:  es = 1'b1;
                12: es = 1'b0;
                16: es = 1'b1;
                20: es = 1'b1;
                24: es = 1'b0;
                default: ;
            endcase
            chk("run_beat", o_lead_beat, (k == 0 || k == 4));
            chk("run_done", o_done, (k == 56));
            chk("run_spawn", o_spawn_note, es);
            chk("run_state", o_state, (k < 4) ? 1 : (k < 20) ? 2 : (k < 56) ? 3 : 0);
            chk("run_idx", o_step_idx, (k < 8) ? 0 : (k < 12) ? 1 : (k < 16) ? 2 : (k < 20) ? 3 : 0);
            if (k >= 40 && k <= 52 && (k % 4) == 0)
                chk("lane_led7", lane[7], exp_led[(k - 40) / 4]);
        end
        chk("run_done_cnt", done_cnt, 1);

        // ---------------- start coincident with strobe ----------------
        cyc(1'b1, 1'b1, 1'b0, 1'b0);        // tick 60 is a strobe phase
        chk("coinc_state", o_state, 1);
        chk("coinc_beat", o_lead_beat, 0);
        for (int k = 1; k <= 8; k++) begin
            tick1();
            chk("coinc_beat_k", o_lead_beat, (k == 4 || k == 8));
        end
        chk("coinc_play", o_state, 2);
        ticks(4);                           // strobe 72: chart[0]
        ticks(4);                           // strobe 76: chart[1]
        chk("pre_pause_idx", o_step_idx, 2);
        chk("pre_pause_spawn", o_spawn_note, 0);
        ticks(3);

        // ---------------- pause coincident with strobe 80 ----------------
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pause_state", o_state, 4);
        chk("pause_idx", o_step_idx, 2);
        chk("pause_spawn", o_spawn_note, 0);
        for (int k = 0; k < 20; k++) begin
            tick1();
            chk("pause_hold_idx", o_step_idx, 2);
            chk("pause_hold_state", o_state, 4);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);        // resume
        chk("resume_state", o_state, 2);
        chk("resume_idx", o_step_idx, 2);
        ticks(3);
        chk("resume_wait_idx", o_step_idx, 2);
        tick1();                            // strobe 104
        chk("resume_spawn", o_spawn_note, 1);
        chk("resume_idx_adv", o_step_idx, 3);

        // ---------------- start in PLAY, then stop+pause ----------------
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_in_play_state", o_state, 2);
        chk("start_in_play_idx", o_step_idx, 3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("stop_pause_state", o_state, 0);
        chk("stop_pause_idx", o_step_idx, 0);
        chk("stop_pause_spawn", o_spawn_note, 0);

        // ---------------- stop during DRAIN ----------------
        cyc(1'b0, 1'b1, 1'b0, 1'b0);        // tick_cnt 105
        ticks(28);                          // through strobe 132 (first drain step)
        chk("drain_state", o_state, 3);
        chk("drain_spawn", o_spawn_note, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain_stop_state", o_state, 0);
        chk("drain_stop_idx", o_step_idx, 0);
        ticks(40);
        chk("drain_stop_idle", o_state, 0);
        chk("drain_stop_no_done", done_cnt, 1);

        // ---------------- reset mid-LEAD ----------------
        cyc(1'b0, 1'b1, 1'b0, 1'b0);        // tick_cnt 173
        ticks(4);                           // strobe 176
        chk("lead_state", o_state, 1);
        chk("lead_beat", o_lead_beat, 1);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_state", o_state, 0);
        chk("midrst_idx", o_step_idx, 0);
        chk("midrst_spawn", o_spawn_note, 0);
        chk("midrst_beat", o_lead_beat, 0);
        chk("midrst_done", o_done, 0);
        rst = 1'b0; tick_cnt = 0; lane = 8'h00;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            tick1();
            chk("replay_beat", o_lead_beat, (k == 0 || k == 4));
            chk("replay_state", o_state, (k < 4) ? 1 : 2);
        end
        chk("final_done_cnt", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/u_note_sched.md
U_NOTE_SCHED -- requirements
Module: u_note_sched

Interface
REQ-001 Parameter NOTE_SPEED, default 200, 1 ms ticks per lane step; SHALL equal the value used by the LED lane block.
REQ-002 Parameter CHART_LEN, default 64, number of chart steps (power of two, >=2).
REQ-003 Parameter LEAD_STEPS, default 8, count-in steps before the chart starts (>=1).
REQ-004 clk  in  1  system clock; the block's only clock.
REQ-005 rst  in  1  synchronous, active-high reset; SHALL be the same net that resets the LED lane block.
REQ-006 i_tick  in  1  1 ms tick, one clk wide.
REQ-007 i_start  in  1  one-clk pulse, begin a song.
REQ-008 i_pause  in  1  one-clk pulse, toggle pause.
REQ-009 i_stop  in  1  one-clk pulse, abort the song.
REQ-010 o_spawn_note  out  1  note bit for the lane's next shift, registered.
REQ-011 o_state  out  3  current state encoding.
REQ-012 o_step_idx  out  $clog2(CHART_LEN)  next chart index to issue.
REQ-013 o_lead_beat  out  1  one-clk pulse per count-in step.
REQ-014 o_done  out  1  one-clk pulse on normal song completion.

Function
REQ-015 Step timer: counter 0..NOTE_SPEED-1, advanced on i_tick, wraps to 0, free-running in all states; strobe = i_tick && counter==0 (phase-identical to the lane's shift enable).
REQ-016 States: IDLE=0, LEAD=1, PLAY=2, DRAIN=3, PAUSE=4.
REQ-017 IDLE: o_spawn_note=0; i_start -> LEAD, lead count=0, o_step_idx=0; a strobe in the same cycle as i_start SHALL NOT count.
REQ-018 LEAD: each strobe -> o_lead_beat pulse, lead count+1; the LEAD_STEPS-th strobe -> PLAY.
REQ-019 PLAY: each strobe -> o_spawn_note <= chart[o_step_idx], o_step_idx+1; the lane consumes that bit at the following strobe (latency = one step).
REQ-020 PLAY, strobe with o_step_idx==CHART_LEN-1 -> load the last bit, o_step_idx wraps to 0, -> DRAIN, drain count=0.
REQ-021 DRAIN: each strobe -> o_spawn_note <= 0, drain count+1; the 9th strobe (1 consume + 8 lane positions) -> IDLE with o_done=1 for that clk.
REQ-022 PAUSE entered from LEAD/PLAY/DRAIN on i_pause: return state saved, o_spawn_note <= 0 next clk, all step/lead/drain counters frozen; strobes ignored.
REQ-023 PAUSE + i_pause -> saved state; the first strobe after resume SHALL be processed normally.
REQ-024 i_stop in any non-IDLE state -> IDLE next clk, o_spawn_note=0, o_step_idx=0, no o_done.
REQ-025 Priority: i_stop > i_pause > strobe; i_start ignored outside IDLE; i_pause ignored in IDLE.
REQ-026 i_pause coincident with a strobe: pause wins; that strobe is discarded.

Reset
REQ-027 While rst is high at a clk edge: state=IDLE, step timer=0, all counters=0, o_spawn_note=0, o_step_idx=0, o_lead_beat=0, o_done=0.
REQ-028 rst mid-song SHALL abort to IDLE without an o_done pulse.

Structure
REQ-029 Shared package u_game_pkg: state encoding, LANE_LEN=8, DRAIN_STEPS=LANE_LEN+1, default NOTE_SPEED.
REQ-030 One sub-module u_chart_rom: CHART_LEN x 1 bit, combinational read by o_step_idx.
REQ-031 Target size 120-400 RTL lines; no other sub-modules.

Verification (NOTE_SPEED=4, CHART_LEN=4, LEAD_STEPS=2, chart=1,0,1,1)
REQ-032 Normal run: i_start -> 2 o_lead_beat pulses 4 ticks apart -> o_spawn_note sequence 1,0,1,1,0 at successive strobes -> o_done exactly 9 strobes after the last chart bit; the lane's o_led[7] shows notes 1,0,1,1 in order.
REQ-033 Pause at PLAY with o_step_idx=2: o_spawn_note=0, o_step_idx holds at 2 for 20 ticks; after resume the next strobe loads chart[2]=1.
REQ-034 i_stop during DRAIN: o_state=0 next clk, o_done never asserted, o_step_idx=0.
REQ-035 i_start coincident with a strobe: first o_lead_beat appears 4 ticks later, not in the same cycle.
REQ-036 i_stop and i_pause in the same clk during PLAY -> IDLE; i_start while in PLAY -> no state change.
REQ-037 rst asserted mid-LEAD -> all outputs 0 on the next clk; a subsequent i_start replays the full count-in.
